check_scoreboard: RTL and testbench
===================================

# check_scoreboard

Downstream companion of the instruction checker `check` in the MIPS verification bench. It records every instruction issued to the DUT (`pcEn` high) and lines it up with the checker's `OpDone` verdict a fixed number of cycles later. It counts passes, failures and spurious `OpDone` pulses, and captures the first failing instruction. A run-control state machine frames a test run and produces a final pass/fail summary for the testbench top.

## Interface
Parameters:
- `LATENCY`, 5: cycles from the `pcEn` sample edge to the edge where the matching `OpDone` is sampled; legal range 1..15.
- `CNT_W`, 16: width of every event counter.

Ports:
- `clk`  in  1  bench clock, shared with `check`.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that opens a run.
- `stop`  in  1  one-cycle pulse that ends issue and starts the drain.
- `inst`  in  32  instruction presented to the DUT and the checker.
- `pcEn`  in  1  instruction-issue strobe, same signal as the checker's input.
- `OpDone`  in  1  checker verdict; 1 means the result matched.
- `issued_cnt`  out  CNT_W  instructions tracked during RUN.
- `pass_cnt`  out  CNT_W  tracked instructions with `OpDone`=1 at the sample slot.
- `fail_cnt`  out  CNT_W  tracked instructions with `OpDone`=0 at the sample slot.
- `spur_cnt`  out  CNT_W  `OpDone`=1 with no tracked instruction in the sample slot.
- `first_fail_inst`  out  32  instruction word of the first failure.
- `first_fail_valid`  out  1  `first_fail_inst` holds a captured word.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.
- `test_pass`  out  1  final verdict; meaningful only while `done` is high.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Encoding is free.
  - IDLE -> RUN on `start`. Entering RUN clears all counters, `first_fail_*` and the tracking pipe.
  - RUN -> DRAIN on `stop`.
  - DRAIN -> DONE once the tracking pipe holds no valid entry.
  - DONE -> RUN on `start`. This restarts with counters cleared.
  - If `start` and `stop` arrive together in IDLE or DONE, `start` wins. In RUN, `start` is ignored. In DRAIN, `stop` is ignored.
- Tracking pipe: a shift register `LATENCY` stages deep. Each stage holds a valid bit and a 32-bit instruction word.
  - Stage 0 loads {`pcEn` && state==RUN, `inst`} every cycle.
  - In DRAIN, stage 0 loads valid=0.
- Sample slot is the last stage. Every cycle, in RUN or DRAIN:
  - slot valid and `OpDone`=1: `pass_cnt`+1.
  - slot valid and `OpDone`=0: `fail_cnt`+1. If `first_fail_valid`=0, capture the word into `first_fail_inst` and set `first_fail_valid`.
  - slot invalid and `OpDone`=1: `spur_cnt`+1.
- `issued_cnt` increments on every stage-0 valid load.
- All counters saturate at all-ones and never wrap.
- `OpDone` is ignored in IDLE and DONE.
- `test_pass` = (`fail_cnt`==0) && (`spur_cnt`==0) && (`issued_cnt`==`pass_cnt`). It is evaluated combinationally from the registered counters.

## Timing
- Reset values:
  - state IDLE.
  - All counters 0.
  - `first_fail_inst` 0, `first_fail_valid` 0.
  - `busy` 0, `done` 0, `test_pass` 0.
  - Pipe valid bits 0.
- `rst` overrides everything, including mid-RUN and mid-DRAIN. In-flight entries are discarded.
- An instruction sampled with `pcEn` at edge t is judged against `OpDone` sampled at edge t+`LATENCY`. The counter update is visible after edge t+`LATENCY`.
- DRAIN lasts exactly `LATENCY` cycles if the pipe was non-empty, else 1 cycle. `done` rises on the edge after the final sample.
- Back-to-back `pcEn` every cycle is supported. There is no throughput limit.
- `busy` and `done` are registered, decoded from state.

## Configuration
- `SCB_PER_OPCODE_EN` defined:
  - Adds output `op_fail_cnt`, 8×CNT_W, one saturating failure counter per class. Index order: R-type (`ADD_op`), `ADDI_op`, `LW_op`, `SW_op`, `BEQ_op`, `BNE_op`, `J_op`, other.
  - Classes are decoded from `inst[31:26]` with the `AluCtrlSig_pkg` opcode constants.
  - Pipe stages also carry a 3-bit class.
  - These counters are cleared on run entry.
- Undefined: the port, the class field and the decoders are absent. All other behaviour is identical.

## Test plan
- Reset, `start`, 10 `pcEn` pulses one cycle apart, `OpDone` echoed 5 cycles later, then `stop` -> `issued_cnt`=10, `pass_cnt`=10, `done`=1 after drain, `test_pass`=1.
- Issue 4 instructions; force `OpDone`=0 for the 2nd (0x00221820) and 4th -> `fail_cnt`=2, `first_fail_inst`=0x00221820, `test_pass`=0.
- `OpDone`=1 with no instruction in flight during RUN -> `spur_cnt`=1, `test_pass`=0. The same pulse in IDLE leaves `spur_cnt`=0.
- `stop` one cycle after the last `pcEn` -> `done` rises only after that instruction's slot has been scored. `pcEn` during DRAIN is not counted.
- Assert `rst` mid-RUN with 3 entries in flight -> state IDLE and all outputs 0 on the next cycle. A later `OpDone` produces no counts.
- Set `CNT_W`=4 and run 20 passing instructions -> `pass_cnt`=15 and `issued_cnt`=15 (saturated), no wrap.

Source files
------------

// File: rtl/check_scoreboard.sv
// check_scoreboard
//
// Scoreboard that sits beside the instruction checker `check`. Every
// instruction issued to the DUT while a run is active is tracked through a
// LATENCY-deep pipe. When it reaches the last stage it is matched against the
// checker's OpDone verdict. Passes, failures and spurious OpDone pulses are
// counted, and the first failing instruction word is captured. A small
// run-control FSM (IDLE -> RUN -> DRAIN -> DONE) frames each run and gives a
// final verdict.
//
// Optional feature: define SCB_PER_OPCODE_EN to add per-opcode-class failure
// counters (output op_fail_cnt). These need the AluCtrlSig_pkg opcode
// constants.
//
// Parameters:
//   LATENCY  cycles from pcEn sample edge to matching OpDone sample edge (1..15)
//   CNT_W    width of every event counter
// Ports:
//   clk, rst          bench clock, synchronous active-high reset
//   start, stop       one-cycle pulses that open a run / begin the drain
//   inst, pcEn        instruction word and issue strobe seen by the DUT
//   OpDone            checker verdict, 1 = result matched
//   issued_cnt        instructions tracked during RUN
//   pass_cnt          tracked instructions with OpDone=1 in the sample slot
//   fail_cnt          tracked instructions with OpDone=0 in the sample slot
//   spur_cnt          OpDone=1 with an empty sample slot
//   first_fail_inst   word of the first failure; first_fail_valid marks it
//   busy, done        state is RUN/DRAIN, state is DONE (registered)
//   test_pass         final verdict, meaningful only while done is high
//   op_fail_cnt       (SCB_PER_OPCODE_EN) 8 packed failure counters, index 0 lowest

module check_scoreboard #(
    parameter int LATENCY = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      inst,
    input  logic             pcEn,
    input  logic             OpDone,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] spur_cnt,
    output logic [31:0]      first_fail_inst,
    output logic             first_fail_valid,
    output logic             busy,
    output logic             done,
    output logic             test_pass
`ifdef SCB_PER_OPCODE_EN
    ,
    output logic [8*CNT_W-1:0] op_fail_cnt
`endif
);

`ifdef SCB_PER_OPCODE_EN
    import AluCtrlSig_pkg::*;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] spur_q, spur_d;
    logic [31:0]      ff_inst_q, ff_inst_d;
    logic             ff_vld_q, ff_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [31:0]        pipe_inst_q [LATENCY];
    logic [31:0]        pipe_inst_d [LATENCY];

`ifdef SCB_PER_OPCODE_EN
    logic [2:0]       pipe_cls_q [LATENCY];
    logic [2:0]       pipe_cls_d [LATENCY];
    logic [CNT_W-1:0] op_fail_q [8];
    logic [CNT_W-1:0] op_fail_d [8];

    function automatic logic [2:0] op_class(input logic [5:0] op);
        if (op == ADD_op)       return 3'd0;
        else if (op == ADDI_op) return 3'd1;
        else if (op == LW_op)   return 3'd2;
        else if (op == SW_op)   return 3'd3;
        else if (op == BEQ_op)  return 3'd4;
        else if (op == BNE_op)  return 3'd5;
        else if (op == J_op)    return 3'd6;
        else                    return 3'd7;
    endfunction
`endif

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic run_entry;
    logic scoring;
    logic issue;

    // Run-control next state.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        run_entry = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // start wins over a simultaneous stop here.
                if (start) begin
                    state_d   = S_RUN;
                    run_entry = 1'b1;
                end
            end
            S_RUN:   if (stop) state_d = S_DRAIN;
            // Pipe empty means the last tracked slot was scored on the previous edge.
            S_DRAIN: if (~|pipe_vld_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Tracking pipe, scoring and counters.
    always_comb begin
        scoring = (state_q == S_RUN) || (state_q == S_DRAIN);
        issue   = pcEn && (state_q == S_RUN);

        issued_d  = issued_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        spur_d    = spur_q;
        ff_inst_d = ff_inst_q;
        ff_vld_d  = ff_vld_q;

        pipe_vld_d[0]  = issue;
        pipe_inst_d[0] = inst;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_inst_d[i] = pipe_inst_q[i-1];
        end

`ifdef SCB_PER_OPCODE_EN
        op_fail_d     = op_fail_q;
        pipe_cls_d[0] = op_class(inst[31:26]);
        for (int i = 1; i < LATENCY; i++) begin
            pipe_cls_d[i] = pipe_cls_q[i-1];
        end
`endif

        if (issue) issued_d = sat_inc(issued_q);

        if (scoring) begin
            if (pipe_vld_q[LATENCY-1]) begin
                if (OpDone) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
`ifdef SCB_PER_OPCODE_EN
                    op_fail_d[pipe_cls_q[LATENCY-1]] = sat_inc(op_fail_q[pipe_cls_q[LATENCY-1]]);
`endif
                    if (!ff_vld_q) begin
                        ff_vld_d  = 1'b1;
                        ff_inst_d = pipe_inst_q[LATENCY-1];
                    end
                end
            end else if (OpDone) begin
                spur_d = sat_inc(spur_q);
            end
        end

        // Entering a run starts from a clean slate; scoring cannot coincide
        // because it only happens in RUN/DRAIN.
        if (run_entry) begin
            issued_d   = '0;
            pass_d     = '0;
            fail_d     = '0;
            spur_d     = '0;
            ff_inst_d  = '0;
            ff_vld_d   = 1'b0;
            pipe_vld_d = '0;
`ifdef SCB_PER_OPCODE_EN
            for (int k = 0; k < 8; k++) op_fail_d[k] = '0;
`endif
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            issued_q   <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            spur_q     <= '0;
            ff_inst_q  <= '0;
            ff_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            spur_q     <= spur_d;
            ff_inst_q  <= ff_inst_d;
            ff_vld_q   <= ff_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // NOTE: pipe payload is not reset; the valid bits alone decide whether a stage is meaningful.
    always_ff @(posedge clk) begin
        pipe_inst_q <= pipe_inst_d;
`ifdef SCB_PER_OPCODE_EN
        pipe_cls_q  <= pipe_cls_d;
`endif
    end

`ifdef SCB_PER_OPCODE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) op_fail_q[k] <= '0;
        end else begin
            op_fail_q <= op_fail_d;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_op_fail
        assign op_fail_cnt[g*CNT_W +: CNT_W] = op_fail_q[g];
    end
`endif

    assign issued_cnt       = issued_q;
    assign pass_cnt         = pass_q;
    assign fail_cnt         = fail_q;
    assign spur_cnt         = spur_q;
    assign first_fail_inst  = ff_inst_q;
    assign first_fail_valid = ff_vld_q;
    assign busy             = busy_q;
    assign done             = done_q;
    // Gated by done so the verdict reads 0 outside DONE, including after reset.
    assign test_pass        = done_q && (fail_q == '0) && (spur_q == '0) && (issued_q == pass_q);

endmodule

// File: tb/tb_check_scoreboard.sv
// Testbench for check_scoreboard. A queue stands in for the tracking pipe:
// each driven cycle pushes the issued instruction and its intended verdict,
// and LATENCY cycles later the entry is popped to drive OpDone and update a
// reference model of the counters. A second instance with CNT_W=4 shares the
// same stimulus and is inspected for saturation.

module tb_check_scoreboard;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst, start, stop, pcEn, OpDone;
    logic [31:0] inst;

    logic [15:0] issued_cnt, pass_cnt, fail_cnt, spur_cnt;
    logic [31:0] first_fail_inst;
    logic        first_fail_valid, busy, done, test_pass;

    logic [3:0]  s_issued, s_pass, s_fail, s_spur;
    logic [31:0] s_ffi;
    logic        s_ffv, s_busy, s_done, s_tp;

    always #5 clk = ~clk;

    check_scoreboard #(.LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .inst(inst),
        .pcEn(pcEn), .OpDone(OpDone),
        .issued_cnt(issued_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .spur_cnt(spur_cnt), .first_fail_inst(first_fail_inst),
        .first_fail_valid(first_fail_valid), .busy(busy), .done(done),
        .test_pass(test_pass)
    );

    check_scoreboard #(.LATENCY(LAT), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .inst(inst),
        .pcEn(pcEn), .OpDone(OpDone),
        .issued_cnt(s_issued), .pass_cnt(s_pass), .fail_cnt(s_fail),
        .spur_cnt(s_spur), .first_fail_inst(s_ffi),
        .first_fail_valid(s_ffv), .busy(s_busy), .done(s_done),
        .test_pass(s_tp)
    );

    typedef struct packed {
        logic        vld;
        logic        verdict;
        logic [31:0] word;
    } ent_t;

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_e;

    ent_t        sb[$];
    mstate_e     m_state;
    int          m_issued, m_pass, m_fail, m_spur;
    logic        m_ffv;
    logic [31:0] m_ffi;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_issued = 0;
        m_pass   = 0;
        m_fail   = 0;
        m_spur   = 0;
        m_ffv    = 1'b0;
        m_ffi    = '0;
        foreach (sb[i]) sb[i].vld = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        logic m_done;
        m_done = (m_state == M_DONE);
        check({ctx, ".issued"}, 32'(issued_cnt), 32'(m_issued));
        check({ctx, ".pass"}, 32'(pass_cnt), 32'(m_pass));
        check({ctx, ".fail"}, 32'(fail_cnt), 32'(m_fail));
        check({ctx, ".spur"}, 32'(spur_cnt), 32'(m_spur));
        check({ctx, ".ffv"}, 32'(first_fail_valid), 32'(m_ffv));
        check({ctx, ".ffi"}, first_fail_inst, m_ffi);
        check({ctx, ".busy"}, 32'(busy), 32'((m_state == M_RUN) || (m_state == M_DRAIN)));
        check({ctx, ".done"}, 32'(done), 32'(m_done));
        check({ctx, ".test_pass"}, 32'(test_pass),
              32'(m_done && (m_fail == 0) && (m_spur == 0) && (m_issued == m_pass)));
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic cycle(input string ctx, input logic st, input logic sp, input logic pe,
                         input logic [31:0] w, input logic verdict, input logic extra);
        ent_t slot;
        logic empty;
        logic od;
        logic issue;
        slot  = sb[0];
        empty = 1'b1;
        foreach (sb[i]) if (sb[i].vld) empty = 1'b0;
        od     = (slot.vld && slot.verdict) || extra;
        start  = st;
        stop   = sp;
        pcEn   = pe;
        inst   = w;
        OpDone = od;
        @(posedge clk);
        slot = sb.pop_front();
        if (rst) begin
            sb.push_back('{vld: 1'b0, verdict: 1'b0, word: 32'h0});
            m_state = M_IDLE;
            model_clear();
        end else begin
            if (m_state == M_RUN || m_state == M_DRAIN) begin
                if (slot.vld) begin
                    if (od) m_pass++;
                    else begin
                        m_fail++;
                        if (!m_ffv) begin
                            m_ffv = 1'b1;
                            m_ffi = slot.word;
                        end
                    end
                end else if (od) begin
                    m_spur++;
                end
            end
            issue = pe && (m_state == M_RUN);
            if (issue) m_issued++;
            sb.push_back('{vld: issue, verdict: verdict, word: w});
            case (m_state)
                M_IDLE, M_DONE: if (st) begin
                    m_state = M_RUN;
                    model_clear();
                end
                M_RUN:   if (sp) m_state = M_DRAIN;
                M_DRAIN: if (empty) m_state = M_DONE;
                default: ;
            endcase
        end
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) cycle(ctx, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Cycles until done rises, optionally strobing pcEn; bounded.
    task automatic wait_done(input string ctx, input logic pe, output int n);
        n = 0;
        while (!done && n < 40) begin
            cycle(ctx, 1'b0, 1'b0, pe, 32'hDEAD0000 + 32'(n), 1'b1, 1'b0);
            n++;
        end
        check({ctx, ".done_reached"}, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w4 [4];
        logic        v4 [4];
        w4 = '{32'h8C010004, 32'h00221820, 32'h20420001, 32'hAC030008};
        v4 = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; pcEn = 1'b0; OpDone = 1'b0; inst = '0;
        m_state = M_IDLE;
        for (int i = 0; i < LAT; i++) sb.push_back('{vld: 1'b0, verdict: 1'b0, word: 32'h0});
        model_clear();

        idle("reset", 2);
        rst = 1'b0;
        check("reset.done", 32'(done), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.test_pass", 32'(test_pass), 32'd0);

        // OpDone in IDLE is ignored.
        cycle("idle_od", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("idle_od.spur", 32'(spur_cnt), 32'd0);

        // 10 back-to-back passing instructions.
        cycle("t1.start", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle("t1.issue", 1'b0, 1'b0, 1'b1, 32'h20000000 + 32'(i), 1'b1, 1'b0);
        cycle("t1.stop", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_done("t1.drain", 1'b0, n);
        check("t1.issued", 32'(issued_cnt), 32'd10);
        check("t1.pass", 32'(pass_cnt), 32'd10);
        check("t1.test_pass", 32'(test_pass), 32'd1);

        // DONE ignores OpDone.
        cycle("done_od", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("done_od.spur", 32'(spur_cnt), 32'd0);

        // Two failures; first captured word is the 2nd instruction. start+stop together: start wins.
        cycle("t2.start", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2.busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) cycle("t2.issue", 1'b0, 1'b0, 1'b1, w4[i], v4[i], 1'b0);
        cycle("t2.stop", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_done("t2.drain", 1'b0, n);
        check("t2.fail", 32'(fail_cnt), 32'd2);
        check("t2.pass", 32'(pass_cnt), 32'd2);
        check("t2.first_fail_inst", first_fail_inst, 32'h00221820);
        check("t2.first_fail_valid", 32'(first_fail_valid), 32'd1);
        check("t2.test_pass", 32'(test_pass), 32'd0);

        // Spurious OpDone during RUN with nothing in flight.
        cycle("t3.start", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle("t3.gap", 2);
        cycle("t3.spur", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle("t3.stop", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_done("t3.drain", 1'b0, n);
        check("t3.spur_cnt", 32'(spur_cnt), 32'd1);
        check("t3.test_pass", 32'(test_pass), 32'd0);

        // stop right after the last pcEn; pcEn strobed through DRAIN must not count.
        cycle("t4.start", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("t4.issue", 1'b0, 1'b0, 1'b1, 32'h10220003 + 32'(i), 1'b1, 1'b0);
        cycle("t4.stop", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_done("t4.drain", 1'b1, n);
        check("t4.drain_cycles", 32'(n), 32'(LAT));
        check("t4.issued", 32'(issued_cnt), 32'd3);
        check("t4.pass", 32'(pass_cnt), 32'd3);
        check("t4.test_pass", 32'(test_pass), 32'd1);

        // Reset mid-RUN with 3 entries in flight.
        cycle("t5.start", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("t5.issue", 1'b0, 1'b0, 1'b1, 32'h08000010 + 32'(i), 1'b1, 1'b0);
        rst = 1'b1;
        cycle("t5.rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        check("t5.issued", 32'(issued_cnt), 32'd0);
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.done", 32'(done), 32'd0);
        for (int i = 0; i < LAT; i++) cycle("t5.late_od", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t5.pass_after", 32'(pass_cnt), 32'd0);
        check("t5.spur_after", 32'(spur_cnt), 32'd0);

        // 20 passing instructions: the CNT_W=4 instance saturates at 15.
        cycle("t6.start", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle("t6.issue", 1'b0, 1'b0, 1'b1, 32'h01000000 + 32'(i), 1'b1, 1'b0);
        cycle("t6.stop", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_done("t6.drain", 1'b0, n);
        check("t6.wide_pass", 32'(pass_cnt), 32'd20);
        check("t6.sat_pass", 32'(s_pass), 32'd15);
        check("t6.sat_issued", 32'(s_issued), 32'd15);
        check("t6.sat_fail", 32'(s_fail), 32'd0);
        check("t6.sat_done", 32'(s_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
